// File: rtl/video_pkg.sv
// Shared defaults, state encoding and a counter-width helper for the
// video frame sequencer.
package video_pkg;

  localparam int H_ACTIVE_DEF  = 640;
  localparam int V_ACTIVE_DEF  = 480;
  localparam int DATA_W_DEF    = 8;
  localparam int FRAME_GAP_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REARM  = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_STREAM = 3'd3,
    ST_GAP    = 3'd4
  } seq_state_e;

  // Counter width for a count of n states, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/video_pos_counter.sv
// Column/row position tracking for one frame; flags the first pixel,
// the end of each line and the expected final pixel.
module video_pos_counter
  import video_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic beat,
  output logic at_sof,
  output logic at_eol,
  output logic at_final
);

  localparam int CW = cnt_w(H_ACTIVE);
  localparam int RW = cnt_w(V_ACTIVE);
  localparam logic [CW-1:0] COL_LAST = CW'(H_ACTIVE - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] COL_ONE  = CW'(1'b1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1'b1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  // Next position: advance on each accepted beat, wrap at line and frame end.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear) begin
      col_d = '0;
      row_d = '0;
    end else if (beat) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        if (row_q == ROW_LAST) begin
          row_d = '0;
        end else begin
          row_d = row_q + ROW_ONE;
        end
      end else begin
        col_d = col_q + COL_ONE;
        row_d = row_q;
      end
    end else begin
      col_d = col_q;
      row_d = row_q;
    end
  end

  // Position registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign at_sof   = (col_q == '0) && (row_q == '0);
  assign at_eol   = (col_q == COL_LAST);
  assign at_final = (col_q == COL_LAST) && (row_q == ROW_LAST);

endmodule

// File: rtl/video_frame_sequencer.sv
// Re-arms and launches a single-shot frame source once per frame and passes
// its pixels to the sink with zero latency, tagging start-of-frame and end-of-line.
module video_frame_sequencer
  import video_pkg::*;
#(
  parameter int H_ACTIVE  = H_ACTIVE_DEF,
  parameter int V_ACTIVE  = V_ACTIVE_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int FRAME_GAP = FRAME_GAP_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              stop,
  input  logic [15:0]       cfg_frames,
  output logic              src_rst,
  output logic              src_start,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_user,
  output logic              m_last,
  input  logic              m_ready,
  output logic              busy,
  output logic              done,
  output logic [15:0]       frame_cnt,
  output logic              err_short,
  output logic              err_long
);

  localparam int GW = cnt_w(FRAME_GAP);
  localparam logic [GW-1:0] GAP_LAST = GW'(FRAME_GAP - 1);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1'b1);

  seq_state_e    state_q, state_d;
  logic [15:0]   frames_q, frames_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          err_short_q, err_short_d;
  logic          err_long_q, err_long_d;
  logic          done_q, done_d;
  logic          src_rst_q, src_rst_d;
  logic          src_start_q, src_start_d;
  logic          busy_q, busy_d;
  logic          stop_seen_q, stop_seen_d;

  logic        in_stream_s, beat_s, frame_end_s, clear_s;
  logic        at_sof_s, at_eol_s, at_final_s;
  logic [15:0] cnt_inc_s;

  assign in_stream_s = (state_q == ST_STREAM);
  assign s_ready     = in_stream_s & m_ready;
  assign m_valid     = in_stream_s & s_valid;
  assign m_data      = s_data;
  assign m_user      = m_valid & at_sof_s;
  assign m_last      = m_valid & at_eol_s;
  assign beat_s      = s_valid & s_ready;
  assign frame_end_s = beat_s & (s_last | at_final_s);
  assign cnt_inc_s   = frame_cnt_q + 16'd1;
  assign clear_s     = (state_d == ST_REARM) && (state_q != ST_REARM);

  video_pos_counter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_pos (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear_s),
    .beat     (beat_s),
    .at_sof   (at_sof_s),
    .at_eol   (at_eol_s),
    .at_final (at_final_s)
  );

  // Sequencer next-state logic.
  always_comb begin
    state_d     = state_q;
    frames_d    = frames_q;
    frame_cnt_d = frame_cnt_q;
    gap_d       = gap_q;
    err_short_d = err_short_q;
    err_long_d  = err_long_q;
    stop_seen_d = stop_seen_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run) begin
          frames_d    = cfg_frames;
          frame_cnt_d = 16'd0;
          err_short_d = 1'b0;
          err_long_d  = 1'b0;
          stop_seen_d = 1'b0;
          state_d     = ST_REARM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REARM:  state_d = ST_LAUNCH;
      ST_LAUNCH: state_d = ST_STREAM;
      ST_STREAM: begin
        stop_seen_d = stop_seen_q | stop;
        if (frame_end_s) begin
          frame_cnt_d = cnt_inc_s;
          gap_d       = '0;
          // A frame that ends off the expected final pixel is flagged either way.
          if (s_last && !at_final_s) begin
            err_short_d = 1'b1;
          end else begin
            err_short_d = err_short_q;
          end
          if (at_final_s && !s_last) begin
            err_long_d = 1'b1;
          end else begin
            err_long_d = err_long_q;
          end
          if ((frames_q != 16'd0) && (cnt_inc_s == frames_q)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else if (stop || stop_seen_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_GAP;
          end
        end else begin
          state_d = ST_STREAM;
        end
      end
      ST_GAP: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (gap_q == GAP_LAST) begin
          state_d = ST_REARM;
        end else begin
          gap_d   = gap_q + GAP_ONE;
          state_d = ST_GAP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    src_rst_d   = (state_d == ST_REARM);
    src_start_d = (state_d == ST_LAUNCH);
    busy_d      = (state_d != ST_IDLE);
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      frames_q    <= 16'd0;
      frame_cnt_q <= 16'd0;
      gap_q       <= '0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      done_q      <= 1'b0;
      src_rst_q   <= 1'b0;
      src_start_q <= 1'b0;
      busy_q      <= 1'b0;
      stop_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      frames_q    <= frames_d;
      frame_cnt_q <= frame_cnt_d;
      gap_q       <= gap_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
      done_q      <= done_d;
      src_rst_q   <= src_rst_d;
      src_start_q <= src_start_d;
      busy_q      <= busy_d;
      stop_seen_q <= stop_seen_d;
    end
  end

  assign src_rst   = src_rst_q;
  assign src_start = src_start_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign frame_cnt = frame_cnt_q;
  assign err_short = err_short_q;
  assign err_long  = err_long_q;

endmodule

// File: tb/tb_video_frame_sequencer.sv
// Randomized bench for video_frame_sequencer on a 4x3 frame; a behavioural
// single-shot source plus protocol-level expectations per scenario.
module tb_video_frame_sequencer;

  localparam int H   = 4;
  localparam int V   = 3;
  localparam int G   = 3;
  localparam int FPX = H * V;

  logic        clk = 1'b0;
  logic        rst, run, stop;
  logic [15:0] cfg_frames;
  logic        src_rst, src_start;
  logic [7:0]  s_data;
  logic        s_valid, s_last, s_ready;
  logic [7:0]  m_data;
  logic        m_valid, m_user, m_last, m_ready;
  logic        busy, done, err_short, err_long;
  logic [15:0] frame_cnt;

  int checks = 0;
  int errors = 0;

  // Behavioural source state and stimulus modes.
  bit src_active = 1'b0;
  int src_idx    = 0;
  int last_at    = FPX;   // beat number carrying s_last, 0 = never
  int valid_mode = 0;     // 0 = always valid, 1 = random
  int ready_mode = 0;     // 0 = always ready, 1 = toggle, 2 = random
  bit tog        = 1'b0;

  always #5 clk = ~clk;

  video_frame_sequencer #(
    .H_ACTIVE  (H),
    .V_ACTIVE  (V),
    .DATA_W    (8),
    .FRAME_GAP (G)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .stop       (stop),
    .cfg_frames (cfg_frames),
    .src_rst    (src_rst),
    .src_start  (src_start),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_user     (m_user),
    .m_last     (m_last),
    .m_ready    (m_ready),
    .busy       (busy),
    .done       (done),
    .frame_cnt  (frame_cnt),
    .err_short  (err_short),
    .err_long   (err_long)
  );

  // One clock: drive source/sink at negedge, settle, then advance the source model.
  task automatic step();
    bit beat;
    @(negedge clk);
    if (src_active) begin
      s_valid = (valid_mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
      s_data  = 8'($urandom);
      s_last  = s_valid && (last_at != 0) && (src_idx + 1 == last_at);
    end else begin
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_data  = 8'($urandom);
    end
    case (ready_mode)
      0: m_ready = 1'b1;
      1: begin m_ready = tog; tog = ~tog; end
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
    #1;
    beat = s_valid & s_ready;
    if (src_rst) begin src_idx = 0; src_active = 1'b0; end
    if (src_start) src_active = 1'b1;
    if (beat) begin
      src_idx++;
      if (s_last) src_active = 1'b0;
    end
  endtask

  // Runs until n frames of exp_len beats complete, checking the handshake,
  // beat tags, re-arm/launch spacing and inter-frame gap on the way.
  task automatic stream_frames(input string tag, input int n, input int exp_len, input int stop_frame);
    int f = 0;
    int k = 0;
    int c = 0;
    int prev_end = -1;
    int srst_c = -1000;
    bit in_stream = 1'b0;
    while (f < n && c < 3000) begin
      step();
      run = 1'b0;
      if (src_rst) begin
        if (prev_end >= 0) begin
          checks++;
          if (c - prev_end != G + 1) begin
            errors++;
            $display("FAIL %s gap: re-arm %0d cycles after frame end, expected %0d", tag, c - prev_end, G + 1);
          end
        end
        srst_c = c;
      end
      if (src_start) begin
        checks++;
        if (c - srst_c != 1) begin
          errors++;
          $display("FAIL %s launch: src_start %0d cycles after src_rst, expected 1", tag, c - srst_c);
        end
      end
      checks++;
      if (s_ready !== (in_stream & m_ready)) begin
        errors++;
        $display("FAIL %s s_ready: got %b expected %b (cycle %0d)", tag, s_ready, in_stream & m_ready, c);
      end
      checks++;
      if (m_valid !== (in_stream & s_valid)) begin
        errors++;
        $display("FAIL %s m_valid: got %b expected %b (cycle %0d)", tag, m_valid, in_stream & s_valid, c);
      end
      if (s_valid && s_ready) begin
        checks += 3;
        if (m_user !== (k == 0)) begin
          errors++;
          $display("FAIL %s m_user: frame %0d beat %0d got %b expected %b", tag, f, k + 1, m_user, k == 0);
        end
        if (m_last !== (k % H == H - 1)) begin
          errors++;
          $display("FAIL %s m_last: frame %0d beat %0d got %b expected %b", tag, f, k + 1, m_last, k % H == H - 1);
        end
        if (m_data !== s_data) begin
          errors++;
          $display("FAIL %s m_data: got %h expected %h", tag, m_data, s_data);
        end
        if (stop_frame == f && k == 4) stop = 1'b1;
        if (stop_frame == f && k == 6) stop = 1'b0;
        k++;
        if (k == exp_len) begin
          f++;
          k = 0;
          in_stream = 1'b0;
          prev_end = c;
        end
      end
      if (src_start) in_stream = 1'b1;
      c++;
    end
    checks++;
    if (f != n) begin
      errors++;
      $display("FAIL %s timeout: %0d frames completed, expected %0d", tag, f, n);
    end
  endtask

  // Checks the cycle right after a finite sequence's last frame.
  task automatic check_finish(input string tag, input int exp_cnt, input bit exp_done,
                              input bit exp_short, input bit exp_long);
    step();
    checks++;
    if ({busy, done, err_short, err_long} !== {1'b0, exp_done, exp_short, exp_long}) begin
      errors++;
      $display("FAIL %s status: busy/done/short/long got %b%b%b%b expected 0%b%b%b",
               tag, busy, done, err_short, err_long, exp_done, exp_short, exp_long);
    end
    checks++;
    if (frame_cnt !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL %s frame_cnt: got %0d expected %0d", tag, frame_cnt, exp_cnt);
    end
    step();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s done_pulse: done still %b a cycle later, expected 0", tag, done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b0; stop = 1'b0; cfg_frames = 16'd0;
    s_valid = 1'b0; s_last = 1'b0; s_data = 8'd0; m_ready = 1'b0;
    repeat (3) step();
    checks++;
    if ({src_rst, src_start, s_ready, m_valid, m_user, m_last, busy, done, err_short, err_long} !== 10'b0) begin
      errors++;
      $display("FAIL reset outputs: got %b expected 0000000000",
               {src_rst, src_start, s_ready, m_valid, m_user, m_last, busy, done, err_short, err_long});
    end
    checks++;
    if (frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset frame_cnt: got %0d expected 0", frame_cnt);
    end
    rst = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset idle: busy got %b expected 0", busy);
    end
  endtask

  task automatic test_basic();
    cfg_frames = 16'd2; last_at = FPX; valid_mode = 0; ready_mode = 0;
    run = 1'b1;
    stream_frames("basic", 2, FPX, -1);
    check_finish("basic", 2, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    cfg_frames = 16'd3; last_at = FPX; valid_mode = 1; ready_mode = 1;
    run = 1'b1;
    stream_frames("backpressure", 3, FPX, -1);
    check_finish("backpressure", 3, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_short_frame();
    cfg_frames = 16'd2; last_at = 7; valid_mode = 1; ready_mode = 2;
    run = 1'b1;
    stream_frames("short", 2, 7, -1);
    check_finish("short", 2, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_long_frame();
    cfg_frames = 16'd1; last_at = 0; valid_mode = 0; ready_mode = 0;
    run = 1'b1;
    stream_frames("long", 1, FPX, -1);
    step();
    checks++;
    if ({err_long, err_short, done} !== 3'b101) begin
      errors++;
      $display("FAIL long flags: long/short/done got %b%b%b expected 101", err_long, err_short, done);
    end
    checks++;
    if (s_ready !== 1'b0 || s_valid !== 1'b1) begin
      errors++;
      $display("FAIL long s_ready: got %b with source valid %b, expected 0 with valid 1", s_ready, s_valid);
    end
    checks++;
    if (frame_cnt !== 16'd1) begin
      errors++;
      $display("FAIL long frame_cnt: got %0d expected 1", frame_cnt);
    end
  endtask

  task automatic test_stop();
    int rearms = 0;
    cfg_frames = 16'd0; last_at = FPX; valid_mode = 1; ready_mode = 2;
    run = 1'b1;
    stream_frames("stop", 3, FPX, 2);
    check_finish("stop", 3, 1'b0, 1'b0, 1'b0);
    repeat (8) begin
      step();
      if (src_rst || busy) rearms++;
    end
    checks++;
    if (rearms != 0) begin
      errors++;
      $display("FAIL stop idle: %0d busy/re-arm cycles after stop, expected 0", rearms);
    end
  endtask

  task automatic test_reset_mid_frame();
    int k = 0;
    int c = 0;
    cfg_frames = 16'd2; last_at = FPX; valid_mode = 0; ready_mode = 0;
    run = 1'b1;
    while (k < 5 && c < 200) begin
      step();
      run = 1'b0;
      if (s_valid && s_ready) k++;
      c++;
    end
    checks++;
    if (k != 5) begin
      errors++;
      $display("FAIL midreset timeout: %0d beats seen, expected 5", k);
    end
    rst = 1'b1;
    step();
    checks++;
    if ({src_rst, src_start, s_ready, m_valid, m_user, m_last, busy, done, err_short, err_long} !== 10'b0) begin
      errors++;
      $display("FAIL midreset outputs: got %b expected 0000000000",
               {src_rst, src_start, s_ready, m_valid, m_user, m_last, busy, done, err_short, err_long});
    end
    rst = 1'b0;
    run = 1'b1;
    stream_frames("restart", 2, FPX, -1);
    check_finish("restart", 2, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_short_frame();
    test_long_frame();
    test_stop();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
